// File: rtl/dispatch.sv
// ---------------------------------------------------------------------------
// dispatch : out-of-order dispatch stage between rename and the ALU, branch
//            and memory execution pipes.
//
//   types_pkg   : rename_data / rs_data structs and shared helper functions.
//   res_station : one reservation station. Holds the entries, wakes them up
//                 from writeback broadcasts, issues the lowest-index ready
//                 entry and drops entries younger than a mispredicted branch.
//   dispatch    : top level. Handshake with rename, physical-register
//                 scoreboard and three station instances (res_alu, res_b,
//                 res_mem).
//
// Ports of dispatch:
//   clk, reset                 clock, synchronous active-high reset
//   valid_in, data_in          renamed instruction from rename
//   ready_in                   dispatch can accept this cycle (combinational)
//   rob_full, rob_index_in     ROB status and tag of the incoming instruction
//                              (the ROB tail while mispredict is high)
//   mispredict, mispredict_tag one-cycle flush pulse and the branch's ROB tag
//   ps_*_in, ps_*_ready        writeback broadcast tags and their valids
//   fu_*_ready                 execution pipe can take an instruction
//   rs_*, *_issued             registered issued entry and its one-cycle strobe
// ---------------------------------------------------------------------------

package types_pkg;

    typedef struct packed {
        logic [1:0]  fu;
        logic [6:0]  pd_new;
        logic [6:0]  ps1;
        logic [6:0]  ps2;
        logic [6:0]  Opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] imm;
    } rename_data;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic        ps1_ready;
        logic        ps2_ready;
        logic [4:0]  rob_index;
        logic [1:0]  fu;
        logic [6:0]  ps1;
        logic [6:0]  ps2;
        logic [6:0]  pd;
        logic [6:0]  Opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] imm;
    } rs_data;

    // Broadcast buses packed as {mem, b, alu}, 7 bits per tag.
    function automatic logic bc_hit(input logic [6:0]  tag,
                                    input logic [2:0]  bc_valid,
                                    input logic [20:0] bc_tags);
        bc_hit = (bc_valid[0] && (bc_tags[6:0]   == tag)) ||
                 (bc_valid[1] && (bc_tags[13:7]  == tag)) ||
                 (bc_valid[2] && (bc_tags[20:14] == tag));
    endfunction

endpackage

// ---------------------------------------------------------------------------
// res_station : RS_DEPTH-entry reservation station.
//   insert, insert_entry     write a new entry into the lowest free slot
//   bc_valid, bc_tags        writeback broadcasts used for wake-up
//   fu_ready                 downstream pipe accepts an issue this cycle
//   flush, flush_tag,
//   flush_tail               drop entries strictly younger than flush_tag and
//                            older than the ROB tail
//   issue_entry, issued      registered issued entry and its strobe
//   full                     every slot is valid
// ---------------------------------------------------------------------------
module res_station
    import types_pkg::*;
#(
    parameter int RS_DEPTH = 8,
    parameter int ROB_MOD  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        insert,
    input  rs_data      insert_entry,
    input  logic [2:0]  bc_valid,
    input  logic [20:0] bc_tags,
    input  logic        fu_ready,
    input  logic        flush,
    input  logic [4:0]  flush_tag,
    input  logic [4:0]  flush_tail,
    output rs_data      issue_entry,
    output logic        issued,
    output logic        full
);

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    rs_data                rs_table [RS_DEPTH];
    logic [RS_DEPTH-1:0]   kill;
    logic [RS_DEPTH-1:0]   wake1;
    logic [RS_DEPTH-1:0]   wake2;
    logic                  issue_go;
    logic [IDX_W-1:0]      sel_idx;
    logic [IDX_W-1:0]      free_idx;

    // Age distance from the mispredicted branch, modulo the ROB size.
    function automatic logic [4:0] rob_dist(input logic [4:0] a, input logic [4:0] b);
        rob_dist = (a - b) & 5'(ROB_MOD - 1);
    endfunction

    // Descending loop so the lowest matching index is the one left standing.
    // Killed entries are excluded from issue so a flushed op never leaves.
    always_comb begin
        kill     = '0;
        wake1    = '0;
        wake2    = '0;
        issue_go = 1'b0;
        sel_idx  = '0;
        free_idx = '0;
        full     = 1'b1;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            kill[i] = flush && rs_table[i].valid &&
                      (rob_dist(rs_table[i].rob_index, flush_tag) != 5'd0) &&
                      (rob_dist(rs_table[i].rob_index, flush_tag) <
                       rob_dist(flush_tail, flush_tag));
            wake1[i] = rs_table[i].ps1_ready || bc_hit(rs_table[i].ps1, bc_valid, bc_tags);
            wake2[i] = rs_table[i].ps2_ready || bc_hit(rs_table[i].ps2, bc_valid, bc_tags);
            if (fu_ready && rs_table[i].valid && rs_table[i].ready && !kill[i]) begin
                issue_go = 1'b1;
                sel_idx  = IDX_W'(i);
            end
            if (!rs_table[i].valid) begin
                free_idx = IDX_W'(i);
            end
            full = full & rs_table[i].valid;
        end
    end

    // Insert only ever targets a free slot while issue/kill only touch valid
    // slots, so the three updates never collide on the same entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                rs_table[i] <= '0;
            end
            issue_entry <= '0;
            issued      <= 1'b0;
        end else begin
            issued <= 1'b0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (kill[i]) begin
                    rs_table[i].valid <= 1'b0;
                end else if (rs_table[i].valid) begin
                    rs_table[i].ps1_ready <= wake1[i];
                    rs_table[i].ps2_ready <= wake2[i];
                    rs_table[i].ready     <= wake1[i] & wake2[i];
                end
            end
            if (issue_go) begin
                rs_table[sel_idx].valid <= 1'b0;
                issue_entry             <= rs_table[sel_idx];
                issued                  <= 1'b1;
            end
            if (insert) begin
                rs_table[free_idx] <= insert_entry;
            end
        end
    end

endmodule

// ---------------------------------------------------------------------------
// dispatch : top level (see file header for the port summary).
// ---------------------------------------------------------------------------
module dispatch
    import types_pkg::*;
#(
    parameter int RS_DEPTH  = 8,
    parameter int NUM_PREGS = 128,
    parameter int ROB_MOD   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  rename_data data_in,
    output logic       ready_in,
    input  logic       rob_full,
    input  logic [4:0] rob_index_in,
    input  logic       mispredict,
    input  logic [4:0] mispredict_tag,
    input  logic [6:0] ps_alu_in,
    input  logic [6:0] ps_b_in,
    input  logic [6:0] ps_mem_in,
    input  logic       ps_alu_ready,
    input  logic       ps_b_ready,
    input  logic       ps_mem_ready,
    input  logic       fu_alu_ready,
    input  logic       fu_b_ready,
    input  logic       fu_mem_ready,
    output rs_data     rs_alu,
    output rs_data     rs_b,
    output rs_data     rs_mem,
    output logic       alu_issued,
    output logic       b_issued,
    output logic       mem_issued
);

    logic [NUM_PREGS-1:0] preg_rtable;
    logic [NUM_PREGS-1:0] preg_next;
    logic                 rs_alu_full;
    logic                 rs_b_full;
    logic                 rs_mem_full;
    logic                 sel_full;
    logic                 accept;
    logic [2:0]           bc_valid;
    logic [20:0]          bc_tags;
    rs_data               new_entry;
    logic                 ps1_rdy;
    logic                 ps2_rdy;

    assign bc_valid = {ps_mem_ready, ps_b_ready, ps_alu_ready};
    assign bc_tags  = {ps_mem_in, ps_b_in, ps_alu_in};

    // fu=00 has no station behind it and is therefore never back-pressured.
    always_comb begin
        sel_full = 1'b0;
        case (data_in.fu)
            2'b01:   sel_full = rs_alu_full;
            2'b10:   sel_full = rs_b_full;
            2'b11:   sel_full = rs_mem_full;
            default: sel_full = 1'b0;
        endcase
    end

    assign ready_in = !rob_full && !mispredict && !sel_full;
    assign accept   = valid_in && ready_in;

    // A source broadcast in the same cycle as the insert counts as ready,
    // otherwise the entry would miss its only wake-up.
    always_comb begin
        ps1_rdy             = preg_rtable[data_in.ps1] || bc_hit(data_in.ps1, bc_valid, bc_tags);
        ps2_rdy             = preg_rtable[data_in.ps2] || bc_hit(data_in.ps2, bc_valid, bc_tags);
        new_entry           = '0;
        new_entry.valid     = 1'b1;
        new_entry.ps1_ready = ps1_rdy;
        new_entry.ps2_ready = ps2_rdy;
        new_entry.ready     = ps1_rdy && ps2_rdy;
        new_entry.rob_index = rob_index_in;
        new_entry.fu        = data_in.fu;
        new_entry.ps1       = data_in.ps1;
        new_entry.ps2       = data_in.ps2;
        new_entry.pd        = data_in.pd_new;
        new_entry.Opcode    = data_in.Opcode;
        new_entry.func3     = data_in.func3;
        new_entry.func7     = data_in.func7;
        new_entry.imm       = data_in.imm;
    end

    // Allocation clears first so a same-cycle broadcast of that tag wins.
    // p0 is the hard-wired zero register and never goes busy.
    always_comb begin
        preg_next = preg_rtable;
        if (accept && data_in.fu[0] && (data_in.pd_new != 7'd0)) begin
            preg_next[data_in.pd_new] = 1'b0;
        end
        if (ps_alu_ready) preg_next[ps_alu_in] = 1'b1;
        if (ps_b_ready)   preg_next[ps_b_in]   = 1'b1;
        if (ps_mem_ready) preg_next[ps_mem_in] = 1'b1;
        preg_next[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            preg_rtable <= '1;
        end else begin
            preg_rtable <= preg_next;
        end
    end

    res_station #(.RS_DEPTH(RS_DEPTH), .ROB_MOD(ROB_MOD)) res_alu (
        .clk          (clk),
        .reset        (reset),
        .insert       (accept && (data_in.fu == 2'b01)),
        .insert_entry (new_entry),
        .bc_valid     (bc_valid),
        .bc_tags      (bc_tags),
        .fu_ready     (fu_alu_ready),
        .flush        (mispredict),
        .flush_tag    (mispredict_tag),
        .flush_tail   (rob_index_in),
        .issue_entry  (rs_alu),
        .issued       (alu_issued),
        .full         (rs_alu_full)
    );

    res_station #(.RS_DEPTH(RS_DEPTH), .ROB_MOD(ROB_MOD)) res_b (
        .clk          (clk),
        .reset        (reset),
        .insert       (accept && (data_in.fu == 2'b10)),
        .insert_entry (new_entry),
        .bc_valid     (bc_valid),
        .bc_tags      (bc_tags),
        .fu_ready     (fu_b_ready),
        .flush        (mispredict),
        .flush_tag    (mispredict_tag),
        .flush_tail   (rob_index_in),
        .issue_entry  (rs_b),
        .issued       (b_issued),
        .full         (rs_b_full)
    );

    res_station #(.RS_DEPTH(RS_DEPTH), .ROB_MOD(ROB_MOD)) res_mem (
        .clk          (clk),
        .reset        (reset),
        .insert       (accept && (data_in.fu == 2'b11)),
        .insert_entry (new_entry),
        .bc_valid     (bc_valid),
        .bc_tags      (bc_tags),
        .fu_ready     (fu_mem_ready),
        .flush        (mispredict),
        .flush_tag    (mispredict_tag),
        .flush_tail   (rob_index_in),
        .issue_entry  (rs_mem),
        .issued       (mem_issued),
        .full         (rs_mem_full)
    );

endmodule

// File: tb/tb_dispatch.sv
// Testbench for dispatch: directed scenarios followed by random traffic, all
// compared against a behavioural model of the stations and scoreboard.
module tb_dispatch;
    import types_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    rename_data data_in;
    logic       ready_in;
    logic       rob_full;
    logic [4:0] rob_index_in;
    logic       mispredict;
    logic [4:0] mispredict_tag;
    logic [6:0] ps_alu_in, ps_b_in, ps_mem_in;
    logic       ps_alu_ready, ps_b_ready, ps_mem_ready;
    logic       fu_alu_ready, fu_b_ready, fu_mem_ready;
    rs_data     rs_alu, rs_b, rs_mem;
    logic       alu_issued, b_issued, mem_issued;

    dispatch dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .ready_in(ready_in), .rob_full(rob_full), .rob_index_in(rob_index_in),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .ps_alu_in(ps_alu_in), .ps_b_in(ps_b_in), .ps_mem_in(ps_mem_in),
        .ps_alu_ready(ps_alu_ready), .ps_b_ready(ps_b_ready), .ps_mem_ready(ps_mem_ready),
        .fu_alu_ready(fu_alu_ready), .fu_b_ready(fu_b_ready), .fu_mem_ready(fu_mem_ready),
        .rs_alu(rs_alu), .rs_b(rs_b), .rs_mem(rs_mem),
        .alu_issued(alu_issued), .b_issued(b_issued), .mem_issued(mem_issued)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        bit       v;
        bit       r1;
        bit       r2;
        bit [4:0] rob;
        bit [6:0] ps1;
        bit [6:0] ps2;
        bit [6:0] pd;
    } ment_t;

    ment_t      mrs [3][8];
    bit [127:0] mtab;
    bit         exp_iss [3];
    bit [4:0]   exp_rob [3];
    bit [6:0]   exp_pd  [3];
    bit         last_acc;
    bit [4:0]   rob_ctr;

    function automatic bit bc_match(input bit [6:0] t);
        return (ps_alu_ready && ps_alu_in == t) || (ps_b_ready && ps_b_in == t) ||
               (ps_mem_ready && ps_mem_in == t);
    endfunction

    // Age of x relative to the branch, modulo a 16-entry ROB.
    function automatic int age(input bit [4:0] x, input bit [4:0] br);
        return (int'(x) - int'(br) + 32) % 16;
    endfunction

    function automatic logic [7:0] dut_mask(input int st, input bit want_ready);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            case (st)
                0: m[i] = dut.res_alu.rs_table[i].valid && (!want_ready || dut.res_alu.rs_table[i].ready);
                1: m[i] = dut.res_b.rs_table[i].valid   && (!want_ready || dut.res_b.rs_table[i].ready);
                default: m[i] = dut.res_mem.rs_table[i].valid && (!want_ready || dut.res_mem.rs_table[i].ready);
            endcase
        end
        return m;
    endfunction

    function automatic logic [7:0] model_mask(input int st, input bit want_ready);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++)
            m[i] = mrs[st][i].v && (!want_ready || (mrs[st][i].r1 && mrs[st][i].r2));
        return m;
    endfunction

    // One clock: inputs are already driven (just after a negedge).
    task automatic step();
        ment_t      nrs [3][8];
        bit [127:0] ntab;
        bit         exp_ready, fr[3], was_reset;
        int         s, cnt, slot, dt;
        logic [7:0] dm;
        #1;
        was_reset = reset;
        fr[0] = fu_alu_ready; fr[1] = fu_b_ready; fr[2] = fu_mem_ready;
        last_acc = 1'b0;
        if (reset) begin
            for (int st = 0; st < 3; st++) begin
                for (int i = 0; i < 8; i++) nrs[st][i] = '0;
                exp_iss[st] = 0; exp_rob[st] = 0; exp_pd[st] = 0;
            end
            ntab = '1;
        end else begin
            s = (data_in.fu == 2'b00) ? 0 : int'(data_in.fu) - 1;
            cnt = 0;
            for (int i = 0; i < 8; i++) if (mrs[s][i].v) cnt++;
            exp_ready = !rob_full && !mispredict && (data_in.fu == 2'b00 || cnt < 8);
            check_val("ready_in", ready_in, exp_ready);
            last_acc = valid_in && exp_ready;
            nrs = mrs;
            dt = age(rob_index_in, mispredict_tag);
            for (int st = 0; st < 3; st++) begin
                exp_iss[st] = 0;
                for (int i = 0; i < 8; i++) begin
                    bit killed;
                    killed = mispredict && mrs[st][i].v &&
                             age(mrs[st][i].rob, mispredict_tag) > 0 &&
                             age(mrs[st][i].rob, mispredict_tag) < dt;
                    if (killed) nrs[st][i].v = 0;
                    else if (!exp_iss[st] && fr[st] && mrs[st][i].v && mrs[st][i].r1 && mrs[st][i].r2) begin
                        exp_iss[st] = 1;
                        exp_rob[st] = mrs[st][i].rob;
                        exp_pd[st]  = mrs[st][i].pd;
                        nrs[st][i].v = 0;
                    end
                    if (nrs[st][i].v) begin
                        nrs[st][i].r1 = nrs[st][i].r1 || bc_match(nrs[st][i].ps1);
                        nrs[st][i].r2 = nrs[st][i].r2 || bc_match(nrs[st][i].ps2);
                    end
                end
            end
            if (last_acc && data_in.fu != 2'b00) begin
                slot = -1;
                for (int i = 7; i >= 0; i--) if (!mrs[s][i].v) slot = i;
                nrs[s][slot].v   = 1;
                nrs[s][slot].r1  = mtab[data_in.ps1] || bc_match(data_in.ps1);
                nrs[s][slot].r2  = mtab[data_in.ps2] || bc_match(data_in.ps2);
                nrs[s][slot].rob = rob_index_in;
                nrs[s][slot].ps1 = data_in.ps1;
                nrs[s][slot].ps2 = data_in.ps2;
                nrs[s][slot].pd  = data_in.pd_new;
            end
            ntab = mtab;
            if (last_acc && (data_in.fu == 2'b01 || data_in.fu == 2'b11) && data_in.pd_new != 0)
                ntab[data_in.pd_new] = 0;
            if (ps_alu_ready) ntab[ps_alu_in] = 1;
            if (ps_b_ready)   ntab[ps_b_in]   = 1;
            if (ps_mem_ready) ntab[ps_mem_in] = 1;
            ntab[0] = 1;
        end
        @(posedge clk);
        #1;
        mrs  = nrs;
        mtab = ntab;
        check_val("alu_issued", alu_issued, exp_iss[0]);
        check_val("b_issued",   b_issued,   exp_iss[1]);
        check_val("mem_issued", mem_issued, exp_iss[2]);
        if (exp_iss[0]) check_val("rs_alu", {rs_alu.rob_index, rs_alu.pd}, {exp_rob[0], exp_pd[0]});
        if (exp_iss[1]) check_val("rs_b",   {rs_b.rob_index, rs_b.pd},     {exp_rob[1], exp_pd[1]});
        if (exp_iss[2]) check_val("rs_mem", {rs_mem.rob_index, rs_mem.pd}, {exp_rob[2], exp_pd[2]});
        if (was_reset) check_val("rs_zero", {rs_alu, rs_b, rs_mem} == '0, 1'b1);
        check_val("preg_rtable", dut.preg_rtable, mtab);
        for (int st = 0; st < 3; st++) begin
            dm = dut_mask(st, 0);
            check_val($sformatf("valid_mask%0d", st), dm, model_mask(st, 0));
            check_val($sformatf("ready_mask%0d", st), dut_mask(st, 1), model_mask(st, 1));
        end
        check_val("full_flags", {dut.rs_mem_full, dut.rs_b_full, dut.rs_alu_full},
                  {model_mask(2, 0) == 8'hff, model_mask(1, 0) == 8'hff, model_mask(0, 0) == 8'hff});
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; valid_in = 0; data_in = '0; rob_full = 0; rob_index_in = rob_ctr;
        mispredict = 0; mispredict_tag = 0;
        ps_alu_in = 0; ps_b_in = 0; ps_mem_in = 0;
        ps_alu_ready = 0; ps_b_ready = 0; ps_mem_ready = 0;
        fu_alu_ready = 0; fu_b_ready = 0; fu_mem_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
        rob_ctr = 0;
    endtask

    task automatic send(input bit [1:0] fu, input bit [6:0] pd, input bit [6:0] s1,
                        input bit [6:0] s2, input bit [4:0] rob);
        valid_in = 1;
        data_in = '0;
        data_in.fu = fu; data_in.pd_new = pd; data_in.ps1 = s1; data_in.ps2 = s2;
        data_in.Opcode = 7'($urandom); data_in.imm = $urandom;
        rob_index_in = rob;
        step();
        valid_in = 0;
    endtask

    int n_iss;

    initial begin
        rob_ctr = 0;
        do_reset();
        do_reset();

        // Scoreboard basics
        send(2'b00, 7'd4, 7'd10, 7'd11, 5'd0);
        check_val("nop_rt4", dut.preg_rtable[4], 1'b1);
        check_val("nop_no_entry", dut_mask(0, 0) | dut_mask(1, 0) | dut_mask(2, 0), 8'h00);
        send(2'b01, 7'd5, 7'd10, 7'd11, 5'd1);
        check_val("alu_rt5", dut.preg_rtable[5], 1'b0);
        send(2'b10, 7'd0, 7'd10, 7'd11, 5'd2);
        check_val("br_rt", dut.preg_rtable, ~(128'd1 << 5));
        send(2'b11, 7'd7, 7'd10, 7'd11, 5'd3);
        check_val("mem_rt7", dut.preg_rtable[7], 1'b0);

        // ROB back-pressure
        rob_full = 1; valid_in = 1; data_in.fu = 2'b01;
        #1 check_val("rob_full_block", ready_in, 1'b0);
        step();
        rob_full = 0; valid_in = 0;
        #1 check_val("rob_release", ready_in, 1'b1);
        step();

        // Fill the ALU station
        for (int k = 0; k < 7; k++) send(2'b01, 7'(20 + k), 7'd10, 7'd11, 5'(4 + k));
        check_val("alu_full", dut.rs_alu_full, 1'b1);
        send(2'b01, 7'd27, 7'd10, 7'd11, 5'd11);
        check_val("full_no_insert_rt27", dut.preg_rtable[27], 1'b1);

        // Broadcasts
        ps_alu_ready = 1; ps_alu_in = 5; step(); ps_alu_ready = 0;
        ps_mem_ready = 1; ps_mem_in = 7; step(); ps_mem_ready = 0;
        check_val("bc_rt5", dut.preg_rtable[5], 1'b1);
        check_val("bc_rt7", dut.preg_rtable[7], 1'b1);
        ps_mem_ready = 1; ps_mem_in = 30;
        send(2'b11, 7'd30, 7'd1, 7'd2, 5'd12);
        ps_mem_ready = 0;
        check_val("bc_wins_rt30", dut.preg_rtable[30], 1'b1);

        // Drain the ALU station
        n_iss = 0;
        fu_alu_ready = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (alu_issued) n_iss++;
        end
        fu_alu_ready = 0;
        check_val("drain_count", n_iss, 8);
        check_val("drain_not_full", dut.rs_alu_full, 1'b0);
        check_val("drain_empty", dut_mask(0, 0), 8'h00);

        // Mispredict, no wrap
        do_reset();
        for (int k = 0; k < 4; k++) send(2'b01, 7'(40 + k), 7'd0, 7'd0, 5'(k));
        mispredict = 1; mispredict_tag = 1; rob_index_in = 4;
        step();
        mispredict = 0;
        check_val("flush_mask", dut_mask(0, 0), 8'h03);

        // Mispredict across the ROB wrap
        do_reset();
        send(2'b01, 7'd50, 7'd0, 7'd0, 5'd14);
        send(2'b01, 7'd51, 7'd0, 7'd0, 5'd15);
        send(2'b01, 7'd52, 7'd0, 7'd0, 5'd0);
        send(2'b01, 7'd53, 7'd0, 7'd0, 5'd1);
        mispredict = 1; mispredict_tag = 15; rob_index_in = 2;
        step();
        mispredict = 0;
        check_val("wrap_flush_mask", dut_mask(0, 0), 8'h03);
        check_val("wrap_keep_rob14", dut.res_alu.rs_table[0].rob_index, 5'd14);

        // Random traffic
        do_reset();
        for (int c = 0; c < 800; c++) begin
            idle();
            reset          = ($urandom_range(0, 249) == 0);
            valid_in       = ($urandom_range(0, 3) != 0);
            data_in.fu     = 2'($urandom_range(0, 3));
            data_in.pd_new = 7'($urandom_range(0, 15));
            data_in.ps1    = 7'($urandom_range(0, 15));
            data_in.ps2    = 7'($urandom_range(0, 15));
            data_in.Opcode = 7'($urandom);
            data_in.imm    = $urandom;
            rob_full       = ($urandom_range(0, 7) == 0);
            mispredict     = ($urandom_range(0, 15) == 0);
            mispredict_tag = rob_ctr - 5'($urandom_range(1, 8));
            rob_index_in   = rob_ctr;
            ps_alu_ready   = ($urandom_range(0, 2) == 0); ps_alu_in = 7'($urandom_range(0, 15));
            ps_b_ready     = ($urandom_range(0, 2) == 0); ps_b_in   = 7'($urandom_range(0, 15));
            ps_mem_ready   = ($urandom_range(0, 2) == 0); ps_mem_in = 7'($urandom_range(0, 15));
            fu_alu_ready   = ($urandom_range(0, 2) == 0);
            fu_b_ready     = ($urandom_range(0, 2) == 0);
            fu_mem_ready   = ($urandom_range(0, 2) == 0);
            step();
            if (reset) rob_ctr = 0;
            else if (last_acc) rob_ctr = rob_ctr + 1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dispatch.md
Name: dispatch

Overview:
- Out-of-order core dispatch stage, between rename and the three execution pipes (ALU, branch, memory).
- Accepts one renamed instruction per cycle and allocates it into one of three 8-entry reservation stations (submodule instances res_alu, res_b, res_mem).
- Tracks physical-register readiness in a 128-bit scoreboard and wakes entries on writeback broadcasts.
- Issues one ready entry per station per cycle and flushes younger entries on branch mispredict.

Parameters:
- RS_DEPTH, 8, entries per reservation station.
- NUM_PREGS, 128, physical registers (7-bit tags).
- ROB_MOD, 16, ROB index modulus used for age comparison.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  rename output valid
- data_in  in  rename_data (types_pkg)  fields used: fu[1:0], pd_new[6:0], ps1[6:0], ps2[6:0], Opcode, func3, func7, imm
- ready_in  out  1  dispatch can accept this cycle
- rob_full  in  1  ROB has no free entry
- rob_index_in  in  5  ROB tag for the incoming instruction; during mispredict, the ROB tail
- mispredict  in  1  one-cycle flush pulse
- mispredict_tag  in  5  ROB tag of the mispredicted branch
- ps_alu_in / ps_b_in / ps_mem_in  in  7 each  broadcast tags
- ps_alu_ready / ps_b_ready / ps_mem_ready  in  1 each  broadcast valid
- fu_alu_ready / fu_b_ready / fu_mem_ready  in  1 each  FU can take an instruction
- rs_alu / rs_b / rs_mem  out  rs_data (types_pkg)  issued entry
- alu_issued / b_issued / mem_issued  out  1 each  issue strobe

Behaviour:
- All state updates on posedge clk.
- Reset:
  - preg_rtable all 1 (ready).
  - All RS entries valid=0.
  - rs_* outputs = '0; *_issued = 0.
- FU encoding:
  - 01: ALU, res_alu.
  - 10: branch, res_b; no destination.
  - 11: memory, res_mem; has destination.
  - 00: accepted handshake, but no RS write and no scoreboard change.
- ready_in (combinational) = !rob_full && !mispredict && !(station selected by data_in.fu is full). fu=00 is never blocked by a full station.
- Accept occurs when valid_in && ready_in at the clock edge. The new entry captures data_in fields, rob_index_in as rob_index, and pd = pd_new.
- Scoreboard:
  - Accept with fu in {01,11} and pd_new != 0 clears preg_rtable[pd_new] (busy).
  - Any ps_x_ready sets preg_rtable[ps_x_in] = 1.
  - Same cycle, same tag: broadcast wins (ends ready).
  - preg_rtable[0] is always 1.
- Entry operand readiness:
  - On insert, a source is ready if preg_rtable[src] = 1 or the source matches a same-cycle broadcast.
  - Valid entries wake when any broadcast tag matches ps1 or ps2.
  - entry.ready = ps1 ready && ps2 ready.
- Issue, per station each cycle:
  - If fu_x_ready and some entry is valid && ready, select the lowest index.
  - At the edge: clear that entry's valid, register it onto rs_x, and pulse x_issued = 1 for one cycle.
  - Otherwise x_issued = 0 and rs_x holds its last value.
  - Issue and insert in the same cycle are allowed; the freed slot is reusable the next cycle.
- Full flag: rs_alu_full (and likewise rs_b_full, rs_mem_full) = all 8 entries valid. It is internal but must be hierarchically visible.
- Hierarchical visibility required: preg_rtable[127:0] and res_alu.rs_table[i] with fields valid, ready, rob_index, ps1, ps2, pd.
- Mispredict flush:
  - Define d(x) = (x − mispredict_tag) mod 16 and dt = (rob_index_in − mispredict_tag) mod 16.
  - Any valid entry with 0 < d(rob_index) < dt is invalidated at the edge.
  - The mispredicted entry itself and older entries survive. Wrap-around is handled by the modulus.
  - No new insert occurs in that cycle.
  - Issue from surviving entries is permitted.
  - preg_rtable is not rolled back.
- Reset mid-operation clears everything at the next edge, regardless of other inputs.

Test Plan:
- Reset, then accept fu=00 pd=4 → no RS entry, preg_rtable[4]=1. Accept ALU pd=5 → preg_rtable[5]=0. Branch pd=0 → no scoreboard change. MEM pd=7 → preg_rtable[7]=0.
- rob_full=1 → ready_in=0 the same cycle. Release → ready_in=1.
- Insert 8 ALU ops total (pd 5, 20–26; ps1=10, ps2=11) → rs_alu_full=1. A further valid ALU op sees ready_in=0 and is not inserted.
- Broadcast 5 on ALU bus, then 7 on MEM bus → preg_rtable[5]=1, preg_rtable[7]=1. Simultaneous accepted alloc and broadcast of pd 30 → preg_rtable[30]=1.
- fu_alu_ready=1 for 10 cycles with the full ALU RS → one alu_issued pulse per cycle, 8 issues, rs_alu_full=0, all entries invalid.
- Mispredict tests, each after reset:
  - ALU ROB tags 0,1,2,3; mispredict_tag=1, tail=4 → ROB 2,3 flushed; exactly 2 valid entries (0,1) remain.
  - ROB tags 14,15,0,1; mispredict_tag=15, tail=2 → ROB 0,1 flushed; 14,15 remain.
